// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART transmitter.
// Each requester has a one-word holding buffer; words are issued to the driver via tx_start/tx_ready.
module uart_tx_arbiter #(
  parameter int NUM_DATA_BITS = 8,
  parameter int ACK_TIMEOUT   = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [NUM_DATA_BITS-1:0] req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [NUM_DATA_BITS-1:0] req1_data,
  output logic                     req1_ready,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     grant_id,
  output logic                     busy,
  output logic                     tx_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     full0_q, full0_d, full1_q, full1_d;
  logic [NUM_DATA_BITS-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                     tx_start_q, tx_start_d;
  logic [NUM_DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                     grant_q, grant_d;
  logic                     last_q, last_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     sel;

  always_comb begin
    state_d    = state_q;
    full0_d    = full0_q;
    full1_d    = full1_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    sel        = (full0_q & full1_q) ? ~last_q : full1_q;

    // Accept only into an empty buffer, so an accept never coincides with an issue-clear.
    if (req0_valid && !full0_q) begin
      full0_d = 1'b1;
      buf0_d  = req0_data;
    end
    if (req1_valid && !full1_q) begin
      full1_d = 1'b1;
      buf1_d  = req1_data;
    end

    case (state_q)
      IDLE: begin
        if (tx_ready && (full0_q || full1_q)) begin
          tx_data_d  = sel ? buf1_q : buf0_q;
          tx_start_d = 1'b1;
          if (sel) full1_d = 1'b0;
          else     full0_d = 1'b0;
          grant_d = sel;
          last_d  = sel;
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // The word is dropped on timeout rather than retried.
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      full0_q    <= 1'b0;
      full1_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      full0_q    <= full0_d;
      full1_q    <= full1_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Buffer contents are qualified by the full flags and need no reset.
  always_ff @(posedge sys_clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  assign req0_ready = ~full0_q;
  assign req1_ready = ~full1_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign tx_err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART driver model.
module tb_uart_tx_arbiter;

  logic       sys_clk, rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       tx_ready, tx_start, grant_id, busy, tx_err;

  uart_tx_arbiter #(.NUM_DATA_BITS(8), .ACK_TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy), .tx_err(tx_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver model: 0 = drop tx_ready when tx_start is seen and hold it low 20 cycles,
  // 1 = never acknowledge, 2 = tx_ready driven directly by the test sequence.
  int drv_mode = 0;
  int drv_hold = 0;
  always @(negedge sys_clk) begin
    if (rst) begin
      drv_hold = 0;
      if (drv_mode != 2) tx_ready = 1'b1;
    end else if (drv_mode == 1) begin
      tx_ready = 1'b1;
    end else if (drv_mode == 0) begin
      if (drv_hold > 0) begin
        drv_hold--;
        if (drv_hold == 0) tx_ready = 1'b1;
      end else if (tx_start === 1'b1) begin
        tx_ready = 1'b0;
        drv_hold = 20;
      end
    end
  end

  // Frame monitor: records {grant_id, tx_data} per start pulse and flags
  // multi-cycle pulses or tx_data moving during a frame.
  logic [8:0] frames[$];
  int         n_starts = 0;
  int         stab_err = 0;
  logic       prev_start = 1'b0;
  logic [7:0] cur_data = 8'h00;
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (tx_start === 1'b1) begin
        if (prev_start) stab_err++;
        frames.push_back({grant_id, tx_data});
        cur_data = tx_data;
        n_starts++;
      end else if (busy === 1'b1 && tx_data !== cur_data) begin
        stab_err++;
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic tick;
    @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic wait_done(input int n, input string name);
    int t;
    t = 0;
    while (!(frames.size() >= n && busy === 1'b0 && req0_ready === 1'b1 &&
             req1_ready === 1'b1 && tx_ready === 1'b1) && t < 500) begin
      tick;
      t++;
    end
    check({name, " completes"}, (t < 500), 1);
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    int         n;
    logic       e0g;
    logic [7:0] e0d;
    logic       e1g;
    logic [7:0] e1d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t, sent0, sent1, starts0, err_at, err_cnt;
    logic       acc0, acc1, busy_at_err;
    logic [8:0] exp6[6];

    // Round-robin history runs across records, starting from reset (last_grant=1).
    tbl[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 2, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1, 1'b1, 8'h33, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h44, 1'b1, 8'h55, 2, 1'b0, 8'h44, 1'b1, 8'h55};
    tbl[3] = '{1'b1, 8'h66, 1'b0, 8'h00, 1, 1'b0, 8'h66, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'h77, 1'b1, 8'h88, 2, 1'b1, 8'h88, 1'b0, 8'h77};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h99, 1, 1'b1, 8'h99, 1'b0, 8'h00};
    exp6 = '{{1'b0, 8'hA0}, {1'b1, 8'hB0}, {1'b0, 8'hA1},
             {1'b1, 8'hB1}, {1'b0, 8'hA2}, {1'b1, 8'hB2}};

    rst = 1'b1; tx_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h5A;
    req1_valid = 1'b0; req1_data = 8'h00;

    // Reset held with req0 offering data, then first issue latency.
    tick; tick; tick;
    check("rst req0_ready", req0_ready, 1);
    check("rst req1_ready", req1_ready, 1);
    check("rst tx_start", tx_start, 0);
    check("rst busy", busy, 0);
    check("rst tx_data", tx_data, 0);
    check("rst grant_id", grant_id, 0);
    check("rst tx_err", tx_err, 0);
    rst = 1'b0;
    tick;
    req0_valid = 1'b0;
    check("accept req0_ready low", req0_ready, 0);
    check("accept no early start", tx_start, 0);
    tick;
    check("first tx_start", tx_start, 1);
    check("first tx_data", tx_data, 8'h5A);
    check("first grant_id", grant_id, 0);
    check("first busy", busy, 1);
    wait_done(1, "first frame");

    // Table of single/dual loads with expected issue order.
    do_reset;
    for (int i = 0; i < 6; i++) begin
      frames.delete();
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      tick;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_done(tbl[i].n, $sformatf("vec%0d", i));
      check($sformatf("vec%0d frame count", i), frames.size(), tbl[i].n);
      if (frames.size() >= 1)
        check($sformatf("vec%0d frame0", i), frames[0], {tbl[i].e0g, tbl[i].e0d});
      if (tbl[i].n == 2 && frames.size() >= 2)
        check($sformatf("vec%0d frame1", i), frames[1], {tbl[i].e1g, tbl[i].e1d});
    end

    // Continuous load on both requesters: grants must alternate.
    do_reset;
    frames.delete();
    sent0 = 0; sent1 = 0; acc0 = 1'b0; acc1 = 1'b0; t = 0;
    do begin
      if (acc0) begin
        sent0++;
        check("rr req0_ready low when full", req0_ready, 0);
      end
      if (acc1) begin
        sent1++;
        check("rr req1_ready low when full", req1_ready, 0);
      end
      req0_valid = (sent0 < 3); req0_data = 8'hA0 + 8'(sent0);
      req1_valid = (sent1 < 3); req1_data = 8'hB0 + 8'(sent1);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick;
      t++;
    end while (!(frames.size() >= 6 && sent0 == 3 && sent1 == 3 && busy === 1'b0 &&
                 req0_ready === 1'b1 && req1_ready === 1'b1) && t < 2000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr completes", (t < 2000), 1);
    check("rr frame count", frames.size(), 6);
    for (int i = 0; i < 6 && i < frames.size(); i++)
      check($sformatf("rr frame%0d", i), frames[i], exp6[i]);

    // Driver never acknowledges: tx_err ACK_TIMEOUT cycles after tx_start, no retry.
    drv_mode = 1;
    tick;
    starts0 = n_starts;
    req0_valid = 1'b1; req0_data = 8'hC3;
    tick;
    req0_valid = 1'b0;
    t = 0;
    while (tx_start !== 1'b1 && t < 10) begin tick; t++; end
    check("to tx_start seen", tx_start, 1);
    err_at = 0; err_cnt = 0; busy_at_err = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (tx_err === 1'b1) begin
        err_cnt++;
        if (err_at == 0) begin err_at = i; busy_at_err = busy; end
      end
    end
    check("to tx_err cycle", err_at, 4);
    check("to tx_err pulses", err_cnt, 1);
    check("to busy at err", busy_at_err, 0);
    check("to no retry", n_starts - starts0, 1);
    check("to req0_ready", req0_ready, 1);

    // Asynchronous reset mid WAIT_DONE with req1 holding a word.
    drv_mode = 0;
    req0_valid = 1'b1; req0_data = 8'hD1;
    tick;
    req0_valid = 1'b0;
    t = 0;
    while (tx_start !== 1'b1 && t < 10) begin tick; t++; end
    req1_valid = 1'b1; req1_data = 8'hD2;
    tick;
    req1_valid = 1'b0;
    tick; tick; tick;
    check("ar pre busy", busy, 1);
    check("ar pre req1_ready", req1_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("ar busy", busy, 0);
    check("ar req0_ready", req0_ready, 1);
    check("ar req1_ready", req1_ready, 1);
    check("ar tx_start", tx_start, 0);
    check("ar tx_data", tx_data, 0);
    check("ar grant_id", grant_id, 0);
    check("ar tx_err", tx_err, 0);
    tick; tick;
    rst = 1'b0;
    starts0 = n_starts;
    for (int i = 0; i < 10; i++) tick;
    check("ar no start after release", n_starts - starts0, 0);
    check("ar post req1_ready", req1_ready, 1);

    // tx_ready low in IDLE blocks issue until it rises.
    drv_mode = 2;
    tx_ready = 1'b0;
    starts0 = n_starts;
    req0_valid = 1'b1; req0_data = 8'hE5;
    tick;
    req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    check("hold no start", n_starts - starts0, 0);
    check("hold busy", busy, 0);
    check("hold req0_ready", req0_ready, 0);
    tx_ready = 1'b1;
    tick;
    check("hold tx_start", tx_start, 1);
    check("hold tx_data", tx_data, 8'hE5);
    check("hold grant_id", grant_id, 0);
    tx_ready = 1'b0;
    tick; tick;
    tx_ready = 1'b1;
    tick; tick;
    check("hold back to idle", busy, 0);

    check("frame pulse/stability violations", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
